// File: rtl/target_update_queue_if.sv
// Bundles the commit-side enqueue signals and the target-cache update port of target_update_queue.
// master = commit/cache side that drives the inputs, slave = the queue itself.
interface target_update_queue_if #(
  parameter int PTR_W = 3
);
  logic             in0_valid;
  logic [31:0]      in0_pc;
  logic [31:0]      in0_target;
  logic [31:0]      in0_pred_target;
  logic [9:0]       in0_BHR;
  logic             in1_valid;
  logic [31:0]      in1_pc;
  logic [31:0]      in1_target;
  logic [31:0]      in1_pred_target;
  logic [9:0]       in1_BHR;
  logic             in_ready;
  logic             hold;
  logic [31:0]      update_pc;
  logic [31:0]      update_target;
  logic [9:0]       update_BHR;
  logic             update_en;
  logic [PTR_W:0]   count;

  modport master (
    output in0_valid, in0_pc, in0_target, in0_pred_target, in0_BHR,
    output in1_valid, in1_pc, in1_target, in1_pred_target, in1_BHR,
    output hold,
    input  in_ready, update_pc, update_target, update_BHR, update_en, count
  );

  modport slave (
    input  in0_valid, in0_pc, in0_target, in0_pred_target, in0_BHR,
    input  in1_valid, in1_pc, in1_target, in1_pred_target, in1_BHR,
    input  hold,
    output in_ready, update_pc, update_target, update_BHR, update_en, count
  );
endinterface

// File: rtl/target_update_queue.sv
// Serialises up to two retired indirect-branch outcomes per cycle into the single-write target-cache update port.
// Optional macro TARGET_UPDATE_FILTER_EN: enqueue only mispredicted slots (target != pred_target).
module target_update_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  target_update_queue_if.slave tq
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] TWO_C   = (PTR_W + 1)'(2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [9:0]  bhr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               update_en_q, update_en_d;
  entry_t             update_q, update_d;

  logic               keep0_s, keep1_s;
  logic               acc0_s, acc1_s;
  logic               drain_s;
  logic [PTR_W-1:0]   slot1_idx_s;

`ifdef TARGET_UPDATE_FILTER_EN
  // Only mispredicted branches need to retrain the target cache.
  always_comb begin
    keep0_s = tq.in0_valid && (tq.in0_target != tq.in0_pred_target);
    keep1_s = tq.in1_valid && (tq.in1_target != tq.in1_pred_target);
  end
`else
  logic pred_unused_s;

  // Every retired indirect branch is forwarded; predicted targets are not consulted.
  always_comb begin
    keep0_s       = tq.in0_valid;
    keep1_s       = tq.in1_valid;
    pred_unused_s = ^{tq.in0_pred_target, tq.in1_pred_target};
  end
`endif

  // Accept, enqueue, drain and occupancy bookkeeping.
  always_comb begin
    mem_d       = mem_q;
    acc0_s      = keep0_s && in_ready_q;
    acc1_s      = keep1_s && in_ready_q;
    drain_s     = (count_q != {(PTR_W + 1){1'b0}}) && !tq.hold;
    // Slot 1 lands directly behind slot 0 when both survive, else at the tail.
    slot1_idx_s = tail_q + PTR_W'(acc0_s);

    if (acc0_s) begin
      mem_d[tail_q] = '{pc: tq.in0_pc, target: tq.in0_target, bhr: tq.in0_BHR};
    end else begin
      mem_d[tail_q] = mem_q[tail_q];
    end

    if (acc1_s) begin
      mem_d[slot1_idx_s] = '{pc: tq.in1_pc, target: tq.in1_target, bhr: tq.in1_BHR};
    end else begin
      mem_d[slot1_idx_s] = mem_d[slot1_idx_s];
    end

    if (drain_s) begin
      update_d    = mem_q[head_q];
      update_en_d = 1'b1;
      head_d      = head_q + {{(PTR_W - 1){1'b0}}, 1'b1};
    end else begin
      update_d    = update_q;
      update_en_d = 1'b0;
      head_d      = head_q;
    end

    tail_d  = tail_q + PTR_W'(acc0_s) + PTR_W'(acc1_s);
    count_d = count_q + (PTR_W + 1)'(acc0_s) + (PTR_W + 1)'(acc1_s) - (PTR_W + 1)'(drain_s);
    // Readiness is registered from the next occupancy so a same-cycle drain never raises it early.
    in_ready_d = (DEPTH_C - count_d) >= TWO_C;
  end

  // Control state and update-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      count_q     <= {(PTR_W + 1){1'b0}};
      in_ready_q  <= 1'b1;
      update_en_q <= 1'b0;
      update_q    <= '{pc: 32'h0000_0000, target: 32'h0000_0000, bhr: 10'h000};
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      update_en_q <= update_en_d;
      update_q    <= update_d;
    end
  end

  // Entry storage; contents are don't-care after reset because pointers are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tq.in_ready      = in_ready_q;
  assign tq.update_en     = update_en_q;
  assign tq.update_pc     = update_q.pc;
  assign tq.update_target = update_q.target;
  assign tq.update_BHR    = update_q.bhr;
  assign tq.count         = count_q;

endmodule

// File: tb/tb_target_update_queue.sv
// Directed bench for target_update_queue: a queue-level reference model checked every cycle,
// plus literal expectations on the observed update stream for each scenario.
module tb_target_update_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  target_update_queue_if #(.PTR_W(PTR_W)) tq ();

  target_update_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .tq    (tq)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [9:0]  bhr;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [9:0]  bhr;
    int          cyc;
  } log_t;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc_cnt     = 0;
  ent_t mq[$];
  logic m_en        = 1'b0;
  ent_t m_upd       = '0;
  bit   m_ok        = 1'b0;
  log_t dlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic bit keeps(input logic v, input logic [31:0] t, input logic [31:0] p);
`ifdef TARGET_UPDATE_FILTER_EN
    return v && (t != p);
`else
    return v == 1'b1;
`endif
  endfunction

  // Reference model: FIFO of outstanding updates, one pop per non-held edge.
  always @(posedge clk) begin
    bit rdy;
    cyc_cnt++;
    if (reset) begin
      mq.delete();
      m_en  = 1'b0;
      m_upd = '0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      rdy = (DEPTH - mq.size()) >= 2;
      if (tq.in0_valid || tq.in1_valid) begin
        vectors++;
        if (!rdy) begin
          miscompares++;
          $display("FAIL protocol: valid input while queue not ready (cycle %0d)", cyc_cnt);
        end
      end
      if (mq.size() > 0 && !tq.hold) begin
        m_upd = mq.pop_front();
        m_en  = 1'b1;
      end else begin
        m_en  = 1'b0;
      end
      if (rdy && keeps(tq.in0_valid, tq.in0_target, tq.in0_pred_target))
        mq.push_back('{pc: tq.in0_pc, tgt: tq.in0_target, bhr: tq.in0_BHR});
      if (rdy && keeps(tq.in1_valid, tq.in1_target, tq.in1_pred_target))
        mq.push_back('{pc: tq.in1_pc, tgt: tq.in1_target, bhr: tq.in1_BHR});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("update_en", 32'(tq.update_en), 32'(m_en));
      chk("update_pc", tq.update_pc, m_upd.pc);
      chk("update_target", tq.update_target, m_upd.tgt);
      chk("update_BHR", 32'(tq.update_BHR), 32'(m_upd.bhr));
      chk("count", 32'(tq.count), 32'(mq.size()));
      chk("in_ready", 32'(tq.in_ready), ((DEPTH - mq.size()) >= 2) ? 32'd1 : 32'd0);
      if (tq.update_en === 1'b1)
        dlog.push_back('{pc: tq.update_pc, tgt: tq.update_target, bhr: tq.update_BHR, cyc: cyc_cnt});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    tq.in0_valid = 1'b0;
    tq.in1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic enq_full(input logic v0, input logic [31:0] pc0, input logic [31:0] t0,
                          input logic [31:0] p0, input logic [9:0] b0,
                          input logic v1, input logic [31:0] pc1, input logic [31:0] t1,
                          input logic [31:0] p1, input logic [9:0] b1);
    tq.in0_valid = v0; tq.in0_pc = pc0; tq.in0_target = t0; tq.in0_pred_target = p0; tq.in0_BHR = b0;
    tq.in1_valid = v1; tq.in1_pc = pc1; tq.in1_target = t1; tq.in1_pred_target = p1; tq.in1_BHR = b1;
    cyc();
  endtask

  // Mispredicted entries (pred = ~target) so they survive the optional filter.
  task automatic enq2(input logic [31:0] pc0, input logic [31:0] pc1);
    enq_full(1'b1, pc0, pc0 + 32'h100, ~(pc0 + 32'h100), pc0[11:2],
             1'b1, pc1, pc1 + 32'h100, ~(pc1 + 32'h100), pc1[11:2]);
  endtask

  task automatic enq1(input logic [31:0] pc0);
    enq_full(1'b1, pc0, pc0 + 32'h100, ~(pc0 + 32'h100), pc0[11:2],
             1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tq.hold = 1'b0;
    tq.in0_valid = 1'b0; tq.in0_pc = 32'h0; tq.in0_target = 32'h0; tq.in0_pred_target = 32'h0; tq.in0_BHR = 10'h0;
    tq.in1_valid = 1'b0; tq.in1_pc = 32'h0; tq.in1_target = 32'h0; tq.in1_pred_target = 32'h0; tq.in1_BHR = 10'h0;
    idle(2);
    reset = 1'b0;
    chk("reset_count", 32'(tq.count), 32'd0);
    chk("reset_in_ready", 32'(tq.in_ready), 32'd1);
    chk("reset_update_en", 32'(tq.update_en), 32'd0);
    chk("reset_update_pc", tq.update_pc, 32'h0);

    // Single entry and its latency.
    dlog.delete();
    enq_full(1'b1, 32'h0040_0010, 32'h0040_0100, 32'h0000_0000, 10'h155,
             1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
    n = cyc_cnt;
    idle(4);
    chk("single_pulses", 32'(dlog.size()), 32'd1);
    if (dlog.size() == 1) begin
      chk("single_pc", dlog[0].pc, 32'h0040_0010);
      chk("single_target", dlog[0].tgt, 32'h0040_0100);
      chk("single_bhr", 32'(dlog[0].bhr), 32'h155);
      chk("single_latency", 32'(dlog[0].cyc), 32'(n + 1));
    end
    chk("single_count", 32'(tq.count), 32'd0);

    // Dual-slot order.
    dlog.delete();
    enq2(32'h1000, 32'h1004);
    idle(4);
    chk("dual_pulses", 32'(dlog.size()), 32'd2);
    if (dlog.size() == 2) begin
      chk("dual_first", dlog[0].pc, 32'h1000);
      chk("dual_second", dlog[1].pc, 32'h1004);
      chk("dual_back_to_back", 32'(dlog[1].cyc - dlog[0].cyc), 32'd1);
    end

    // Fill under hold, backpressure at 8 and 7, drain in order across the pointer wrap.
    dlog.delete();
    tq.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq2(32'h2000 + 32'(8 * i), 32'h2004 + 32'(8 * i));
      chk("fill_count", 32'(tq.count), 32'(2 * i + 2));
      chk("fill_in_ready", 32'(tq.in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    tq.hold = 1'b0;
    cyc();
    chk("full_minus1_count", 32'(tq.count), 32'd7);
    chk("full_minus1_in_ready", 32'(tq.in_ready), 32'd0);
    idle(10);
    chk("fill_pulses", 32'(dlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dlog.size()) chk("fill_order", dlog[i].pc, 32'h2000 + 32'(4 * i));
    end
    chk("fill_drained", 32'(tq.count), 32'd0);

    // Hold mid-drain: no loss, no repeat.
    dlog.delete();
    tq.hold = 1'b1;
    enq2(32'h3000, 32'h3004);
    enq2(32'h3008, 32'h300C);
    tq.hold = 1'b0;
    idle(2);
    tq.hold = 1'b1;
    idle(3);
    chk("hold_pulses_during", 32'(dlog.size()), 32'd2);
    tq.hold = 1'b0;
    idle(4);
    chk("hold_pulses_total", 32'(dlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dlog.size()) chk("hold_order", dlog[i].pc, 32'h3000 + 32'(4 * i));
    end

    // Reset mid-operation discards queued entries.
    tq.hold = 1'b1;
    enq2(32'h4000, 32'h4004);
    enq2(32'h4008, 32'h400C);
    enq1(32'h4010);
    chk("pre_reset_count", 32'(tq.count), 32'd5);
    tq.hold = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midreset_update_en", 32'(tq.update_en), 32'd0);
    chk("midreset_count", 32'(tq.count), 32'd0);
    chk("midreset_in_ready", 32'(tq.in_ready), 32'd1);
    dlog.delete();
    idle(6);
    chk("midreset_no_stale", 32'(dlog.size()), 32'd0);

    // Mispredict filter.
    dlog.delete();
    enq_full(1'b1, 32'h5000, 32'h2000, 32'h2000, 10'h0AA,
             1'b1, 32'h5004, 32'h3000, 32'h2F00, 10'h0BB);
    idle(4);
`ifdef TARGET_UPDATE_FILTER_EN
    chk("filter_pulses", 32'(dlog.size()), 32'd1);
    if (dlog.size() == 1) begin
      chk("filter_pc", dlog[0].pc, 32'h5004);
      chk("filter_target", dlog[0].tgt, 32'h3000);
    end
`else
    chk("nofilter_pulses", 32'(dlog.size()), 32'd2);
    if (dlog.size() == 2) begin
      chk("nofilter_first", dlog[0].pc, 32'h5000);
      chk("nofilter_second", dlog[1].pc, 32'h5004);
      chk("nofilter_target", dlog[1].tgt, 32'h3000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
